// File: rtl/maze_motion_engine.sv
// Tile-map motion engine: steps N_ENT sprites one pixel per frame_tick, trying the buffered turn first.
// Build option TUNNEL_WRAP_EN: horizontal moves off the map edge wrap through an open edge tile.
module maze_motion_engine #(
   parameter int  N_ENT   = 5,
   parameter int  MAP_W   = 28,
   parameter int  MAP_H   = 31,
   parameter int  TILE_SH = 3,
   parameter int  HALF    = 4,
   parameter int  POS_W   = 10,
   localparam int SEL_W   = (N_ENT > 1) ? $clog2(N_ENT) : 1,
   localparam int ROW_W   = (MAP_H > 1) ? $clog2(MAP_H) : 1,
   localparam int COL_W   = (MAP_W > 1) ? $clog2(MAP_W) : 1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_tick,
   input  logic                   map_we,
   input  logic [ROW_W-1:0]       map_row,
   input  logic [COL_W-1:0]       map_col,
   input  logic [1:0]             map_data,
   input  logic                   ent_load,
   input  logic [SEL_W-1:0]       ent_sel,
   input  logic [POS_W-1:0]       ent_x,
   input  logic [POS_W-1:0]       ent_y,
   input  logic [1:0]             ent_dir,
   input  logic [2*N_ENT-1:0]     dir_req,
   input  logic [N_ENT-1:0]       dir_req_vld,
   output logic [POS_W*N_ENT-1:0] pos_x,
   output logic [POS_W*N_ENT-1:0] pos_y,
   output logic [2*N_ENT-1:0]     cur_dir,
   output logic [N_ENT-1:0]       moving,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);
   typedef logic signed [POS_W:0] scoord_t;
   typedef enum logic [2:0] {S_IDLE, S_CHK_DES, S_CHK_CUR, S_UPD, S_DONE} state_t;

   localparam scoord_t ONE     = scoord_t'(1);
   localparam scoord_t HALF_LO = scoord_t'(HALF);
   localparam scoord_t HALF_HI = scoord_t'(HALF - 1);
   localparam scoord_t ROWS    = scoord_t'(MAP_H);
   localparam scoord_t COLS    = scoord_t'(MAP_W);
   localparam scoord_t X_SPAN  = scoord_t'(MAP_W << TILE_SH);
   localparam logic [ROW_W:0] ROW_LIM = (ROW_W+1)'(MAP_H);
   localparam logic [COL_W:0] COL_LIM = (COL_W+1)'(MAP_W);
   localparam logic [SEL_W:0] SEL_LIM = (SEL_W+1)'(N_ENT);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic             ok_q, ok_d;
   logic [POS_W-1:0] new_x_q, new_x_d, new_y_q, new_y_d;
   logic [1:0]       new_dir_q, new_dir_d;
   logic [POS_W-1:0] pos_x_q [N_ENT];
   logic [POS_W-1:0] pos_x_d [N_ENT];
   logic [POS_W-1:0] pos_y_q [N_ENT];
   logic [POS_W-1:0] pos_y_d [N_ENT];
   logic [1:0]       cur_dir_q [N_ENT];
   logic [1:0]       cur_dir_d [N_ENT];
   logic [1:0]       des_dir_q [N_ENT];
   logic [1:0]       des_dir_d [N_ENT];
   logic [N_ENT-1:0] moving_q, moving_d;
   logic             overrun_q, overrun_d;
   logic [1:0]       map_q [MAP_H][MAP_W];
   logic [1:0]       map_d [MAP_H][MAP_W];

   // Candidate evaluation for entity idx_q in the direction under test this cycle
   logic [1:0]       chk_dir;
   scoord_t          cx, cy, lead;
   scoord_t          row_c [2];
   scoord_t          col_c [2];
   logic             row_in, col_in;
   logic [1:0]       tile;
   logic [1:0]       corner_ok;
   logic             cand_ok;
   logic [POS_W-1:0] cand_x, cand_y;

   always_comb begin
      chk_dir   = (state_q == S_CHK_DES) ? des_dir_q[idx_q] : cur_dir_q[idx_q];
      cx        = $signed({1'b0, pos_x_q[idx_q]});
      cy        = $signed({1'b0, pos_y_q[idx_q]});
      lead      = '0;
      row_c     = '{default: '0};
      col_c     = '{default: '0};
      row_in    = 1'b0;
      col_in    = 1'b0;
      tile      = 2'b00;
      corner_ok = 2'b00;
      unique case (chk_dir)
         2'b00:   cy = cy - ONE;
         2'b01:   cx = cx - ONE;
         2'b10:   cy = cy + ONE;
         default: cx = cx + ONE;
      endcase
      // Only the two corners on the leading edge can enter a new tile
      if (chk_dir[0]) begin
         lead     = chk_dir[1] ? cx + HALF_HI : cx - HALF_LO;
         col_c[0] = lead >>> TILE_SH;
         col_c[1] = lead >>> TILE_SH;
         row_c[0] = (cy - HALF_LO) >>> TILE_SH;
         row_c[1] = (cy + HALF_HI) >>> TILE_SH;
      end else begin
         lead     = chk_dir[1] ? cy + HALF_HI : cy - HALF_LO;
         row_c[0] = lead >>> TILE_SH;
         row_c[1] = lead >>> TILE_SH;
         col_c[0] = (cx - HALF_LO) >>> TILE_SH;
         col_c[1] = (cx + HALF_HI) >>> TILE_SH;
      end
      for (int k = 0; k < 2; k++) begin
         row_in = !row_c[k][POS_W] && (row_c[k] < ROWS);
         col_in = !col_c[k][POS_W] && (col_c[k] < COLS);
         tile   = 2'b00;
         if (row_in && col_in)
            tile = map_q[row_c[k][ROW_W-1:0]][col_c[k][COL_W-1:0]];
`ifdef TUNNEL_WRAP_EN
         else if (row_in && chk_dir[0])
            tile = map_q[row_c[k][ROW_W-1:0]][chk_dir[1] ? COL_W'(MAP_W - 1) : '0];
`endif
         // Doors are passable for ghosts only
         corner_ok[k] = (tile == 2'd1) || ((tile == 2'd2) && (idx_q != '0));
      end
      cand_ok = &corner_ok;
`ifdef TUNNEL_WRAP_EN
      if (cx[POS_W])
         cx = X_SPAN - ONE;
      else if (cx == X_SPAN)
         cx = '0;
`endif
      cand_x = cx[POS_W-1:0];
      cand_y = cy[POS_W-1:0];
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ok_d      = ok_q;
      new_x_d   = new_x_q;
      new_y_d   = new_y_q;
      new_dir_d = new_dir_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      cur_dir_d = cur_dir_q;
      des_dir_d = des_dir_q;
      moving_d  = moving_q;
      overrun_d = overrun_q;
      map_d     = map_q;
      for (int i = 0; i < N_ENT; i++)
         if (dir_req_vld[i]) des_dir_d[i] = dir_req[2*i +: 2];
      if (frame_tick && (state_q != S_IDLE)) overrun_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (map_we && ({1'b0, map_row} < ROW_LIM) && ({1'b0, map_col} < COL_LIM))
               map_d[map_row][map_col] = map_data;
            if (ent_load && ({1'b0, ent_sel} < SEL_LIM)) begin
               pos_x_d[ent_sel]   = ent_x;
               pos_y_d[ent_sel]   = ent_y;
               cur_dir_d[ent_sel] = ent_dir;
               des_dir_d[ent_sel] = ent_dir;
            end
            if (frame_tick) begin
               state_d = S_CHK_DES;
               idx_d   = '0;
            end
         end
         S_CHK_DES: begin
            ok_d      = cand_ok;
            new_x_d   = cand_x;
            new_y_d   = cand_y;
            new_dir_d = chk_dir;
            state_d   = S_CHK_CUR;
         end
         S_CHK_CUR: begin
            if (!ok_q) begin
               ok_d      = cand_ok;
               new_x_d   = cand_x;
               new_y_d   = cand_y;
               new_dir_d = chk_dir;
            end
            state_d = S_UPD;
         end
         S_UPD: begin
            moving_d[idx_q] = ok_q;
            if (ok_q) begin
               pos_x_d[idx_q]   = new_x_q;
               pos_y_d[idx_q]   = new_y_q;
               cur_dir_d[idx_q] = new_dir_q;
            end
            if (idx_q == SEL_W'(N_ENT - 1)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + SEL_W'(1);
               state_d = S_CHK_DES;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         ok_q      <= 1'b0;
         new_x_q   <= '0;
         new_y_q   <= '0;
         new_dir_q <= 2'b00;
         pos_x_q   <= '{default: '0};
         pos_y_q   <= '{default: '0};
         cur_dir_q <= '{default: '0};
         des_dir_q <= '{default: '0};
         moving_q  <= '0;
         overrun_q <= 1'b0;
         map_q     <= '{default: '{default: '0}};
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ok_q      <= ok_d;
         new_x_q   <= new_x_d;
         new_y_q   <= new_y_d;
         new_dir_q <= new_dir_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         cur_dir_q <= cur_dir_d;
         des_dir_q <= des_dir_d;
         moving_q  <= moving_d;
         overrun_q <= overrun_d;
         map_q     <= map_d;
      end
   end

   for (genvar i = 0; i < N_ENT; i++) begin : g_out
      assign pos_x[i*POS_W +: POS_W] = pos_x_q[i];
      assign pos_y[i*POS_W +: POS_W] = pos_y_q[i];
      assign cur_dir[2*i +: 2]       = cur_dir_q[i];
   end

   assign moving  = moving_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign overrun = overrun_q;
endmodule

// File: tb/tb_maze_motion_engine.sv
// Directed and randomized checks of maze_motion_engine against a pixel/tile reference model.
module tb_maze_motion_engine;
   localparam int N_ENT = 5, MAP_W = 28, MAP_H = 31, TILE_SH = 3, HALF = 4, POS_W = 10;
   localparam int TILE = 1 << TILE_SH;

   logic                   Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0, map_we = 1'b0, ent_load = 1'b0;
   logic [4:0]             map_row = '0, map_col = '0;
   logic [1:0]             map_data = '0, ent_dir = '0;
   logic [2:0]             ent_sel = '0;
   logic [POS_W-1:0]       ent_x = '0, ent_y = '0;
   logic [2*N_ENT-1:0]     dir_req = '0;
   logic [N_ENT-1:0]       dir_req_vld = '0;
   logic [POS_W*N_ENT-1:0] pos_x, pos_y;
   logic [2*N_ENT-1:0]     cur_dir;
   logic [N_ENT-1:0]       moving;
   logic                   busy, done, overrun;

   int n_vec = 0, n_err = 0;
   int m_map [MAP_H][MAP_W];
   int m_x [N_ENT], m_y [N_ENT], m_cur [N_ENT], m_des [N_ENT], m_mov [N_ENT];

   maze_motion_engine dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .map_we(map_we), .map_row(map_row),
      .map_col(map_col), .map_data(map_data), .ent_load(ent_load), .ent_sel(ent_sel),
      .ent_x(ent_x), .ent_y(ent_y), .ent_dir(ent_dir), .dir_req(dir_req), .dir_req_vld(dir_req_vld),
      .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir), .moving(moving), .busy(busy), .done(done),
      .overrun(overrun));

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---- reference model: sprite box [p-HALF, p+HALF-1], tiles TILE px wide ----
   function automatic int fdiv(input int v);
      return (v >= 0) ? v / TILE : -((-v + TILE - 1) / TILE);
   endfunction

   function automatic int tile_ok(input int ent, input int r, input int c, input int d);
      if (r < 0 || r >= MAP_H) return 0;
      if (c < 0 || c >= MAP_W) begin
`ifdef TUNNEL_WRAP_EN
         if (d == 1) c = 0;
         else if (d == 3) c = MAP_W - 1;
         else return 0;
`else
         return 0;
`endif
      end
      return (m_map[r][c] == 1 || (m_map[r][c] == 2 && ent != 0)) ? 1 : 0;
   endfunction

   task automatic try_move(input int ent, input int d, output int ok, output int nx, output int ny);
      int lx, hx, ly, hy;
      nx = m_x[ent] + (d == 3 ? 1 : 0) - (d == 1 ? 1 : 0);
      ny = m_y[ent] + (d == 2 ? 1 : 0) - (d == 0 ? 1 : 0);
      lx = fdiv(nx - HALF); hx = fdiv(nx + HALF - 1);
      ly = fdiv(ny - HALF); hy = fdiv(ny + HALF - 1);
      case (d)
         0:       ok = tile_ok(ent, ly, lx, d) & tile_ok(ent, ly, hx, d);
         2:       ok = tile_ok(ent, hy, lx, d) & tile_ok(ent, hy, hx, d);
         1:       ok = tile_ok(ent, ly, lx, d) & tile_ok(ent, hy, lx, d);
         default: ok = tile_ok(ent, ly, hx, d) & tile_ok(ent, hy, hx, d);
      endcase
`ifdef TUNNEL_WRAP_EN
      if (nx < 0) nx = MAP_W * TILE - 1;
      else if (nx == MAP_W * TILE) nx = 0;
`endif
   endtask

   task automatic model_pass();
      int ok, nx, ny;
      for (int i = 0; i < N_ENT; i++) begin
         try_move(i, m_des[i], ok, nx, ny);
         if (ok != 0) begin
            m_x[i] = nx; m_y[i] = ny; m_cur[i] = m_des[i]; m_mov[i] = 1;
         end else begin
            try_move(i, m_cur[i], ok, nx, ny);
            if (ok != 0) begin m_x[i] = nx; m_y[i] = ny; end
            m_mov[i] = ok;
         end
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < MAP_H; r++) for (int c = 0; c < MAP_W; c++) m_map[r][c] = 0;
      for (int i = 0; i < N_ENT; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_cur[i] = 0; m_des[i] = 0; m_mov[i] = 0;
      end
   endtask

   // ---- stimulus helpers: all start and end on a falling edge ----
   task automatic write_tile(input int r, input int c, input int v);
      map_we = 1'b1; map_row = 5'(r); map_col = 5'(c); map_data = 2'(v);
      @(negedge Clk);
      map_we = 1'b0;
      m_map[r][c] = v;
   endtask

   task automatic load_ent(input int i, input int x, input int y, input int d);
      ent_load = 1'b1; ent_sel = 3'(i); ent_x = POS_W'(x); ent_y = POS_W'(y); ent_dir = 2'(d);
      @(negedge Clk);
      ent_load = 1'b0;
      m_x[i] = x; m_y[i] = y; m_cur[i] = d; m_des[i] = d;
   endtask

   task automatic req_dir(input int i, input int d);
      dir_req[2*i +: 2] = 2'(d); dir_req_vld[i] = 1'b1;
      @(negedge Clk);
      dir_req_vld = '0;
      m_des[i] = d;
   endtask

   // Runs one pass; a late request for entity 0 lands on the edge closing its CHK_DES.
   task automatic do_pass(input int late, input int late_dir);
      int lat;
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      if (late != 0) begin dir_req[1:0] = 2'(late_dir); dir_req_vld = 5'b00001; end
      lat = 0;
      for (int k = 1; k <= 64; k++) begin
         if (done) begin lat = k; break; end
         @(negedge Clk);
         dir_req_vld = '0;
      end
      chk("done_latency", lat, 3 * N_ENT + 1);
      @(negedge Clk);
      chk("done_pulse_width", int'(done), 0);
      chk("idle_after_pass", int'(busy), 0);
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < N_ENT; i++) begin
         chk($sformatf("%s_x%0d", tag, i), int'(pos_x[i*POS_W +: POS_W]), m_x[i]);
         chk($sformatf("%s_y%0d", tag, i), int'(pos_y[i*POS_W +: POS_W]), m_y[i]);
         chk($sformatf("%s_dir%0d", tag, i), int'(cur_dir[2*i +: 2]), m_cur[i]);
         chk($sformatf("%s_mov%0d", tag, i), int'(moving[i]), m_mov[i]);
      end
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int n_done, v;
      model_reset();
      @(negedge Clk);
      apply_reset();
      check_all("reset");
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_overrun", int'(overrun), 0);

      // corridor in row 1, columns 1..12
      for (int c = 1; c <= 12; c++) write_tile(1, c, 1);
      load_ent(0, 12, 12, 3);
      do_pass(0, 0); model_pass();
      check_all("t1");
      chk("t1_x_const", int'(pos_x[POS_W-1:0]), 13);

      load_ent(0, 12, 12, 3);
      req_dir(0, 0);
      do_pass(0, 0); model_pass();
      check_all("t2");
      chk("t2_dir_const", int'(cur_dir[1:0]), 3);

      load_ent(0, 12, 12, 1);
      do_pass(0, 0); model_pass();
      check_all("t3");
      chk("t3_mov_const", int'(moving[0]), 0);

      // desired changes on the CHK_DES edge: this pass still steers right
      load_ent(0, 13, 12, 3);
      do_pass(1, 1); model_pass(); m_des[0] = 1;
      check_all("late1");
      chk("late1_x_const", int'(pos_x[POS_W-1:0]), 14);
      do_pass(0, 0); model_pass();
      check_all("late2");
      chk("late2_dir_const", int'(cur_dir[1:0]), 1);

      write_tile(2, 1, 2);
      load_ent(0, 12, 12, 2);
      load_ent(1, 12, 12, 2);
      do_pass(0, 0); model_pass();
      check_all("t4");
      chk("t4_e0_y_const", int'(pos_y[POS_W-1:0]), 12);
      chk("t4_e1_y_const", int'(pos_y[2*POS_W-1:POS_W]), 13);

      for (int c = 0; c < MAP_W; c++) write_tile(14, c, 1);
      load_ent(0, 0, 116, 1);
      do_pass(0, 0); model_pass();
      check_all("t5");
`ifdef TUNNEL_WRAP_EN
      chk("t5_wrap_x", int'(pos_x[POS_W-1:0]), 223);
      chk("t5_wrap_mov", int'(moving[0]), 1);
`else
      chk("t5_edge_x", int'(pos_x[POS_W-1:0]), 0);
      chk("t5_edge_mov", int'(moving[0]), 0);
`endif

      // second tick five cycles into the pass is dropped and flagged
      frame_tick = 1'b1; @(negedge Clk); frame_tick = 1'b0;
      repeat (4) @(negedge Clk);
      frame_tick = 1'b1; @(negedge Clk); frame_tick = 1'b0;
      n_done = 0;
      for (int k = 0; k < 40; k++) begin if (done) n_done++; @(negedge Clk); end
      chk("ovr_done_count", n_done, 1);
      chk("ovr_sticky", int'(overrun), 1);
      model_pass();
      check_all("ovr");

      // reset in the middle of a pass
      frame_tick = 1'b1; @(negedge Clk); frame_tick = 1'b0;
      repeat (6) @(negedge Clk);
      Reset = 1'b1; @(negedge Clk); Reset = 1'b0;
      model_reset();
      n_done = 0;
      for (int k = 0; k < 30; k++) begin if (done) n_done++; @(negedge Clk); end
      chk("abort_no_done", n_done, 0);
      chk("abort_overrun", int'(overrun), 0);
      chk("abort_busy", int'(busy), 0);
      check_all("abort");

      // randomized maps, placements and turn requests
      for (int m = 0; m < 3; m++) begin
         apply_reset();
         for (int r = 0; r < MAP_H; r++)
            for (int c = 0; c < MAP_W; c++) begin
               v = $urandom_range(0, 19);
               write_tile(r, c, (v < 12) ? 1 : (v < 15) ? 2 : (v < 17) ? 0 : 3);
            end
         for (int i = 0; i < N_ENT; i++)
            load_ent(i, 8 * $urandom_range(0, 27) + 4, 8 * $urandom_range(0, 30) + 4, $urandom_range(0, 3));
         for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < N_ENT; i++)
               if ($urandom_range(0, 1) == 1) req_dir(i, $urandom_range(0, 3));
            do_pass(0, 0); model_pass();
            check_all($sformatf("rnd%0d_%0d", m, p));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
